vga_range_ctrl: RTL and testbench
=================================

VGA_RANGE_CTRL -- requirements
Module: vga_range_ctrl

Interface
REQ-001 Parameter UPPER_TH, 20000: peak above this SHALL step gain down.
REQ-002 Parameter LOWER_TH, 5000: peak below this SHALL step gain up.
REQ-003 Parameter STEP, 3 (3-bit): gain code change per adjustment.
REQ-004 Parameter SETTLE_CYCLES, 1000 (16-bit, >=1): clk cycles of settling after each gain load.
REQ-005 Parameter GAIN_INIT, 16 (5-bit): gain code after reset.
REQ-006 Parameter HOLDOFF, 4 (4-bit, >=1): consecutive under-threshold evaluations required before an up-step (VGA_HOLDOFF_EN only).
REQ-007 clk  in  1  system clock; the single clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 auto_enable  in  1  1 = automatic ranging, 0 = manual gain.
REQ-010 ready  in  1  one-cycle pulse: signal_max_a..d valid for a new measurement.
REQ-011 vga_manual  in  5  gain code applied in manual mode.
REQ-012 signal_max_a, signal_max_b, signal_max_c, signal_max_d  in  16 each  unsigned channel amplitudes.
REQ-013 vga_out  out  5  registered gain code to the VGA.
REQ-014 vga_load  out  1  one-cycle strobe when vga_out changes.
REQ-015 busy  out  1  high in EVAL, LOAD, SETTLE; measurements invalid.
REQ-016 over_range  out  1  peak above UPPER_TH with vga_out already 0.
REQ-017 under_range  out  1  peak below LOWER_TH with vga_out already 31.

Function
REQ-018 FSM states SHALL be IDLE, EVAL, LOAD, SETTLE; each state one cycle except SETTLE.
REQ-019 IDLE, auto_enable=1, ready=1: register peak = max(signal_max_a..d), go to EVAL.
REQ-020 IDLE, auto_enable=0, vga_manual != vga_out: latch vga_manual as next gain, go to LOAD; ready ignored.
REQ-021 EVAL: peak > UPPER_TH gives next = vga_out - STEP, clamped at 0; peak < LOWER_TH gives next = vga_out + STEP, clamped at 31; otherwise hold; equality SHALL hold.
REQ-022 Clamp arithmetic SHALL use at least 6 bits; no 5-bit wrap-around.
REQ-023 EVAL: next != vga_out goes to LOAD, else to IDLE.
REQ-024 EVAL SHALL update over_range and under_range per REQ-016/017; both hold their value between evaluations and are unchanged by manual loads.
REQ-025 LOAD: vga_out <= next, vga_load=1 for exactly this cycle, load counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-026 SETTLE: decrement each cycle, return to IDLE the cycle after the counter reads 0; busy high for exactly 2+SETTLE_CYCLES cycles for an auto change.
REQ-027 ready asserted outside IDLE SHALL be dropped, neither queued nor counted.
REQ-028 auto_enable change mid-sequence SHALL NOT abort it; the new mode takes effect in IDLE.
REQ-029 Latency: ready in cycle N gives vga_load in cycle N+2 when a change is needed.

Reset
REQ-030 While rst=1: state IDLE, vga_out=GAIN_INIT, vga_load=0, busy=0, over_range=0, under_range=0, counters and peak cleared.
REQ-031 Reset asserted mid-sequence SHALL take effect immediately, with no vga_load on release.
REQ-032 After release the first ready SHALL be accepted in the first IDLE cycle.

Configuration
REQ-033 Macro VGA_HOLDOFF_EN defined: an up-step SHALL occur only on the HOLDOFF-th consecutive under-threshold evaluation; any other evaluation result or any gain load clears the run counter.
REQ-034 VGA_HOLDOFF_EN undefined: up-steps are immediate per REQ-021; no run counter is synthesised.

Verification
REQ-035 Reset, auto=1, ready with peaks {30000,100,100,100} -> vga_out 16->13, one vga_load at N+2, busy 1002 cycles.
REQ-036 vga_out=1, peak 40000 -> vga_out 0; then peak 40000 again -> no vga_load, over_range=1.
REQ-037 vga_out=30, peak 1000, macro undefined -> vga_out 31; next peak 1000 -> under_range=1, no load.
REQ-038 Peak exactly 20000 or 5000 -> no change, busy high 1 cycle (EVAL only).
REQ-039 auto=0, vga_manual=7 -> one vga_load, vga_out=7, ready pulses during SETTLE ignored.
REQ-040 VGA_HOLDOFF_EN, HOLDOFF=4, peak 1000 four times -> vga_out rises only on the 4th; one mid-run peak of 10000 restarts the count.

Source files
------------

// File: rtl/vga_range_ctrl.sv
// vga_range_ctrl: automatic / manual gain ranging for a variable-gain amplifier.
// It takes the peak of four channel amplitudes and steps the 5-bit gain code
// down when the peak is above UPPER_TH and up when it is below LOWER_TH. After
// each gain load the block waits SETTLE_CYCLES clocks before it accepts
// another measurement.
// Optional feature: define VGA_HOLDOFF_EN to require HOLDOFF consecutive
// under-threshold evaluations before an up-step is taken.
module vga_range_ctrl #(
  parameter logic [15:0] UPPER_TH      = 16'd20000,
  parameter logic [15:0] LOWER_TH      = 16'd5000,
  parameter logic [2:0]  STEP          = 3'd3,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
  parameter logic [4:0]  GAIN_INIT     = 5'd16,
  parameter logic [3:0]  HOLDOFF       = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_enable,
  input  logic        ready,
  input  logic [4:0]  vga_manual,
  input  logic [15:0] signal_max_a,
  input  logic [15:0] signal_max_b,
  input  logic [15:0] signal_max_c,
  input  logic [15:0] signal_max_d,
  output logic [4:0]  vga_out,
  output logic        vga_load,
  output logic        busy,
  output logic        over_range,
  output logic        under_range
);

  typedef enum logic [1:0] {IDLE, EVAL, LOAD, SETTLE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  gain_q, gain_d;
  logic [4:0]  next_q, next_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] cnt_q, cnt_d;
  logic        over_q, over_d;
  logic        under_q, under_d;

  logic [15:0] max_ab, max_cd, max_all;
  logic [5:0]  gain_ext, step_ext, up_sum, down_diff;
  logic [4:0]  up_gain, down_gain, eval_gain;
  logic        peak_hi, peak_lo;

  // Four-way maximum of the channel amplitudes.
  assign max_ab  = (signal_max_a > signal_max_b) ? signal_max_a : signal_max_b;
  assign max_cd  = (signal_max_c > signal_max_d) ? signal_max_c : signal_max_d;
  assign max_all = (max_ab > max_cd) ? max_ab : max_cd;

  // Step arithmetic is carried out in 6 bits so that a clamp can never wrap
  // around (for example 30+3 must give 31, not 1).
  assign gain_ext  = {1'b0, gain_q};
  assign step_ext  = {3'b000, STEP};
  assign up_sum    = gain_ext + step_ext;
  assign down_diff = gain_ext - step_ext;
  assign up_gain   = (up_sum > 6'd31) ? 5'd31 : up_sum[4:0];
  assign down_gain = (gain_ext < step_ext) ? 5'd0 : down_diff[4:0];

  // Equality with either threshold counts as in band.
  assign peak_hi = (peak_q > UPPER_TH);
  assign peak_lo = (peak_q < LOWER_TH);

`ifdef VGA_HOLDOFF_EN
  logic [3:0] run_q, run_d;
  logic       up_allow;

  // An up-step is allowed on the HOLDOFF-th consecutive low evaluation.
  assign up_allow = (({1'b0, run_q} + 5'd1) >= {1'b0, HOLDOFF});

  // Run counter of consecutive under-threshold evaluations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= '0;
    else     run_q <= run_d;
  end
`endif

  // Gain proposed by the current evaluation (equal to gain_q means hold).
  always_comb begin
    eval_gain = gain_q;
`ifdef VGA_HOLDOFF_EN
    run_d = run_q;
    if (state_q == EVAL) begin
      run_d = '0;
      if (peak_hi) begin
        eval_gain = down_gain;
      end else if (peak_lo) begin
        if (up_allow) eval_gain = up_gain;
        else          run_d     = run_q + 4'd1;
      end
    end else if (state_q == LOAD) begin
      run_d = '0;
    end
`else
    if (peak_hi)      eval_gain = down_gain;
    else if (peak_lo) eval_gain = up_gain;
`endif
  end

  // State, gain, peak and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gain_q  <= GAIN_INIT;
      next_q  <= GAIN_INIT;
      peak_q  <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      next_q  <= next_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  // Next-state logic. ready outside IDLE is simply not looked at, so it is
  // dropped; auto_enable is only sampled in IDLE, so a mode change never
  // aborts a sequence that is already running.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    next_d  = next_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    under_d = under_q;
    case (state_q)
      IDLE: begin
        if (auto_enable) begin
          if (ready) begin
            peak_d  = max_all;
            state_d = EVAL;
          end
        end else if (vga_manual != gain_q) begin
          next_d  = vga_manual;
          state_d = LOAD;
        end
      end
      EVAL: begin
        over_d  = peak_hi && (gain_q == 5'd0);
        under_d = peak_lo && (gain_q == 5'd31);
        if (eval_gain != gain_q) begin
          next_d  = eval_gain;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        gain_d  = next_q;
        cnt_d   = SETTLE_CYCLES - 16'd1;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign vga_out     = gain_q;
  assign vga_load    = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign over_range  = over_q;
  assign under_range = under_q;

endmodule

// File: tb/tb_vga_range_ctrl.sv
// Directed testbench for vga_range_ctrl (default parameters).
module tb_vga_range_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auto_enable = 1'b1;
  logic        ready = 1'b0;
  logic [4:0]  vga_manual = 5'd16;
  logic [15:0] sa = '0, sb = '0, sc = '0, sd = '0;
  logic [4:0]  vga_out;
  logic        vga_load, busy, over_range, under_range;

  int checks = 0;
  int fails  = 0;
  int busy_n, loads, load_at;

  vga_range_ctrl dut (
    .clk(clk), .rst(rst), .auto_enable(auto_enable), .ready(ready),
    .vga_manual(vga_manual),
    .signal_max_a(sa), .signal_max_b(sb), .signal_max_c(sc), .signal_max_d(sd),
    .vga_out(vga_out), .vga_load(vga_load), .busy(busy),
    .over_range(over_range), .under_range(under_range)
  );

  always #5 clk = ~clk;

  // From the current negedge, count busy cycles and load strobes until busy
  // drops. Optionally fire an auto-mode ready pulse deep inside SETTLE.
  task automatic watch(input bit poke, output int b_n, output int l_n, output int l_at);
    b_n = 0; l_n = 0; l_at = -1;
    for (int i = 1; i < 3000; i++) begin
      if (!busy) break;
      b_n++;
      if (vga_load) begin l_n++; l_at = i; end
      if (poke && i == 500) begin
        auto_enable = 1'b1; sa = 16'd30000; ready = 1'b1;
      end
      if (poke && i == 501) ready = 1'b0;
      @(negedge clk);
    end
  endtask

  // Pulse ready for one cycle with the given amplitudes and watch the sequence.
  task automatic measure(input logic [15:0] a, b, c, d, output int b_n, output int l_n, output int l_at);
    @(negedge clk);
    sa = a; sb = b; sc = c; sd = d; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    watch(1'b0, b_n, l_n, l_at);
  endtask

  // Force a gain through manual mode, then return to automatic mode.
  task automatic set_gain(input logic [4:0] g);
    @(negedge clk);
    auto_enable = 1'b0; vga_manual = g;
    @(negedge clk);
    watch(1'b0, busy_n, loads, load_at);
    auto_enable = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (vga_out !== 5'd16) begin fails++; $display("FAIL reset_vga_out: got %0d expected 16", vga_out); end
    checks++; if (vga_load !== 1'b0) begin fails++; $display("FAIL reset_vga_load: got %b expected 0", vga_load); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (over_range !== 1'b0) begin fails++; $display("FAIL reset_over: got %b expected 0", over_range); end
    checks++; if (under_range !== 1'b0) begin fails++; $display("FAIL reset_under: got %b expected 0", under_range); end
    rst = 1'b0;
    $display("reset: vga_out=%0d busy=%b", vga_out, busy);
  endtask

  task automatic test_down_step();
    measure(16'd30000, 16'd100, 16'd100, 16'd100, busy_n, loads, load_at);
    $display("down_step: vga_out=%0d loads=%0d load_at=%0d busy=%0d", vga_out, loads, load_at, busy_n);
    checks++; if (vga_out !== 5'd13) begin fails++; $display("FAIL down_vga_out: got %0d expected 13", vga_out); end
    checks++; if (loads != 1) begin fails++; $display("FAIL down_loads: got %0d expected 1", loads); end
    checks++; if (load_at != 2) begin fails++; $display("FAIL down_latency: got %0d expected 2", load_at); end
    checks++; if (busy_n != 1002) begin fails++; $display("FAIL down_busy: got %0d expected 1002", busy_n); end
  endtask

  task automatic test_threshold_equal();
    measure(16'd20000, 16'd10, 16'd10, 16'd10, busy_n, loads, load_at);
    $display("eq_upper: vga_out=%0d loads=%0d busy=%0d", vga_out, loads, busy_n);
    checks++; if (busy_n != 1) begin fails++; $display("FAIL eq_upper_busy: got %0d expected 1", busy_n); end
    checks++; if (loads != 0) begin fails++; $display("FAIL eq_upper_loads: got %0d expected 0", loads); end
    measure(16'd5000, 16'd5000, 16'd5000, 16'd5000, busy_n, loads, load_at);
    $display("eq_lower: vga_out=%0d loads=%0d busy=%0d", vga_out, loads, busy_n);
    checks++; if (busy_n != 1) begin fails++; $display("FAIL eq_lower_busy: got %0d expected 1", busy_n); end
    checks++; if (loads != 0) begin fails++; $display("FAIL eq_lower_loads: got %0d expected 0", loads); end
    checks++; if (vga_out !== 5'd13) begin fails++; $display("FAIL eq_vga_out: got %0d expected 13", vga_out); end
  endtask

  task automatic test_manual();
    int stray;
    @(negedge clk);
    auto_enable = 1'b0; vga_manual = 5'd7;
    @(negedge clk);
    watch(1'b1, busy_n, loads, load_at);
    stray = 0;
    repeat (6) begin
      if (busy || vga_load) stray++;
      @(negedge clk);
    end
    $display("manual: vga_out=%0d loads=%0d load_at=%0d busy=%0d stray=%0d", vga_out, loads, load_at, busy_n, stray);
    checks++; if (vga_out !== 5'd7) begin fails++; $display("FAIL manual_vga_out: got %0d expected 7", vga_out); end
    checks++; if (loads != 1) begin fails++; $display("FAIL manual_loads: got %0d expected 1", loads); end
    checks++; if (busy_n != 1001) begin fails++; $display("FAIL manual_busy: got %0d expected 1001", busy_n); end
    checks++; if (stray != 0) begin fails++; $display("FAIL settle_ready_dropped: got %0d busy cycles expected 0", stray); end
  endtask

  task automatic test_over_range();
    set_gain(5'd1);
    measure(16'd40000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("over1: vga_out=%0d loads=%0d over=%b", vga_out, loads, over_range);
    checks++; if (vga_out !== 5'd0) begin fails++; $display("FAIL over_clamp: got %0d expected 0", vga_out); end
    checks++; if (over_range !== 1'b0) begin fails++; $display("FAIL over_first: got %b expected 0", over_range); end
    measure(16'd0, 16'd40000, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("over2: vga_out=%0d loads=%0d over=%b busy=%0d", vga_out, loads, over_range, busy_n);
    checks++; if (loads != 0) begin fails++; $display("FAIL over_no_load: got %0d expected 0", loads); end
    checks++; if (over_range !== 1'b1) begin fails++; $display("FAIL over_flag: got %b expected 1", over_range); end
    set_gain(5'd5);
    $display("over_manual: vga_out=%0d over=%b", vga_out, over_range);
    checks++; if (over_range !== 1'b1) begin fails++; $display("FAIL over_hold_manual: got %b expected 1", over_range); end
    measure(16'd10000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("over_clear: vga_out=%0d over=%b", vga_out, over_range);
    checks++; if (over_range !== 1'b0) begin fails++; $display("FAIL over_clear: got %b expected 0", over_range); end
    checks++; if (vga_out !== 5'd5) begin fails++; $display("FAIL in_band_hold: got %0d expected 5", vga_out); end
  endtask

  task automatic test_under_range();
    set_gain(5'd30);
`ifdef VGA_HOLDOFF_EN
    repeat (3) measure(16'd1000, 16'd1000, 16'd500, 16'd0, busy_n, loads, load_at);
`endif
    measure(16'd1000, 16'd1000, 16'd500, 16'd0, busy_n, loads, load_at);
    $display("under1: vga_out=%0d loads=%0d under=%b", vga_out, loads, under_range);
    checks++; if (vga_out !== 5'd31) begin fails++; $display("FAIL under_clamp: got %0d expected 31", vga_out); end
    checks++; if (under_range !== 1'b0) begin fails++; $display("FAIL under_first: got %b expected 0", under_range); end
    measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("under2: vga_out=%0d loads=%0d under=%b", vga_out, loads, under_range);
    checks++; if (loads != 0) begin fails++; $display("FAIL under_no_load: got %0d expected 0", loads); end
    checks++; if (under_range !== 1'b1) begin fails++; $display("FAIL under_flag: got %b expected 1", under_range); end
  endtask

  task automatic test_reset_mid();
    int l_cnt;
    @(negedge clk);
    sa = 16'd30000; sb = 0; sc = 0; sd = 0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    rst = 1'b1;
    #1;
    $display("reset_mid: vga_out=%0d busy=%b under=%b", vga_out, busy, under_range);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (vga_out !== 5'd16) begin fails++; $display("FAIL mid_reset_gain: got %0d expected 16", vga_out); end
    checks++; if (under_range !== 1'b0) begin fails++; $display("FAIL mid_reset_under: got %b expected 0", under_range); end
    @(negedge clk);
    rst = 1'b0;
    l_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (vga_load || busy) l_cnt++;
    end
    checks++; if (l_cnt != 0) begin fails++; $display("FAIL mid_reset_release: got %0d active cycles expected 0", l_cnt); end
    measure(16'd30000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("after_reset: vga_out=%0d load_at=%0d", vga_out, load_at);
    checks++; if (vga_out !== 5'd13) begin fails++; $display("FAIL post_reset_step: got %0d expected 13", vga_out); end
  endtask

`ifdef VGA_HOLDOFF_EN
  task automatic test_holdoff();
    repeat (3) measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    checks++; if (vga_out !== 5'd13) begin fails++; $display("FAIL holdoff_early: got %0d expected 13", vga_out); end
    measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("holdoff4: vga_out=%0d loads=%0d", vga_out, loads);
    checks++; if (vga_out !== 5'd16) begin fails++; $display("FAIL holdoff_fourth: got %0d expected 16", vga_out); end
    repeat (2) measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    measure(16'd10000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    repeat (3) measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    checks++; if (vga_out !== 5'd16) begin fails++; $display("FAIL holdoff_restart: got %0d expected 16", vga_out); end
    measure(16'd1000, 16'd0, 16'd0, 16'd0, busy_n, loads, load_at);
    $display("holdoff_restart: vga_out=%0d", vga_out);
    checks++; if (vga_out !== 5'd19) begin fails++; $display("FAIL holdoff_restart4: got %0d expected 19", vga_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_down_step();
    test_threshold_equal();
    test_manual();
    test_over_range();
    test_under_range();
    test_reset_mid();
`ifdef VGA_HOLDOFF_EN
    test_holdoff();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
